mem_arbiter: RTL and testbench

Two-to-one arbiter between the instruction-cache miss port and the data-cache miss port, driving the single physical memory port.
- Sits directly upstream of hazard_detection: the caches' i_mem_resp/d_mem_resp stall behaviour depends on when this block completes each line transfer.
- Serialises line fills and write-backs.
- Latches each granted request so requesters may change inputs after grant.
- Flags a memory timeout.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arb_timer.sv | 33 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache memory arbiter: LC-3b word/line types,
// arbiter state encoding and the line-alignment helper.
package mem_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    localparam int LINE_OFFSET_W = 4;

    // Memory transfers whole 16-byte lines, so the byte offset is always dropped.
    function automatic lc3b_word line_align(input lc3b_word addr);
        lc3b_word aligned;
        aligned = addr;
        aligned[LINE_OFFSET_W-1:0] = '0;
        return aligned;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating SERVE-cycle counter for the memory arbiter; expire is raised
// combinationally during the cycle that completes TIMEOUT_CYCLES of service.
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_COUNT  = '1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX_COUNT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && !clear && (count >= LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter serialising I-cache fills and D-cache fills/write-backs
// onto one physical memory port. Define MEM_ARB_RR_EN for round-robin grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req_read,
    input  lc3b_word    i_req_addr,
    output lc3b_block   i_rdata,
    output logic        i_resp,

    input  logic        d_req_read,
    input  logic        d_req_write,
    input  lc3b_word    d_req_addr,
    input  lc3b_block   d_wdata,
    output lc3b_block   d_rdata,
    output logic        d_resp,

    output logic        pmem_read,
    output logic        pmem_write,
    output lc3b_word    pmem_addr,
    output lc3b_block   pmem_wdata,
    input  lc3b_block   pmem_rdata,
    input  logic        pmem_resp,

    output logic        err_timeout
);

    arb_state_t state;
    logic       serving;
    logic       timer_expire;
    logic       d_want;
    logic       grant_d;
    logic       grant_i;

`ifdef MEM_ARB_RR_EN
    grant_t     last_grant;
`endif

    assign serving = (state == SERVE_I) || (state == SERVE_D);
    assign d_want  = d_req_read || d_req_write;

    mem_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!serving),
        .enable (serving),
        .expire (timer_expire)
    );

    // When both sides ask at once, round-robin favours whoever was not served last.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
`ifdef MEM_ARB_RR_EN
            grant_d = d_want && (!i_req_read || (last_grant == GRANT_I));
`else
            grant_d = d_want;
`endif
            grant_i = i_req_read && !grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            pmem_addr   <= '0;
            pmem_wdata  <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            i_resp      <= 1'b0;
            d_resp      <= 1'b0;
            err_timeout <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant  <= GRANT_I;
`endif
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= SERVE_D;
                        pmem_addr  <= line_align(d_req_addr);
                        pmem_wdata <= d_wdata;
                        pmem_write <= d_req_write;
                        pmem_read  <= !d_req_write;
`ifdef MEM_ARB_RR_EN
                        last_grant <= GRANT_D;
`endif
                    end else if (grant_i) begin
                        state      <= SERVE_I;
                        pmem_addr  <= line_align(i_req_addr);
                        pmem_wdata <= '0;
                        pmem_write <= 1'b0;
                        pmem_read  <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_grant <= GRANT_I;
`endif
                    end
                end

                // A real response wins over a timeout landing in the same cycle.
                SERVE_I, SERVE_D: begin
                    if (pmem_resp || timer_expire) begin
                        state      <= DONE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        if (!pmem_resp) begin
                            err_timeout <= 1'b1;
                        end
                        if (state == SERVE_I) begin
                            i_resp  <= 1'b1;
                            i_rdata <= pmem_resp ? pmem_rdata : '0;
                        end else begin
                            d_resp  <= 1'b1;
                            d_rdata <= pmem_resp ? pmem_rdata : '0;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(d_req_read && d_req_write));
    assert property (@(posedge clk) disable iff (!rst_n) !(pmem_read && pmem_write));
    assert property (@(posedge clk) disable iff (!rst_n) !(i_resp && d_resp));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (timeout shortened to 8 cycles).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      i_req_read;
    lc3b_word  i_req_addr;
    lc3b_block i_rdata;
    logic      i_resp;
    logic      d_req_read;
    logic      d_req_write;
    lc3b_word  d_req_addr;
    lc3b_block d_wdata;
    lc3b_block d_rdata;
    logic      d_resp;
    logic      pmem_read;
    logic      pmem_write;
    lc3b_word  pmem_addr;
    lc3b_block pmem_wdata;
    lc3b_block pmem_rdata;
    logic      pmem_resp;
    logic      err_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int i_resp_seen = 0;
    int d_resp_seen = 0;
    int overlap_seen = 0;

    localparam lc3b_block PAT_A = {16{8'hAA}};
    localparam lc3b_block PAT_W = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam lc3b_block PAT_X = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam lc3b_block PAT_Y = 128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0;
    localparam lc3b_block PAT_Z = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_BEEF;

    mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_read(i_req_read), .i_req_addr(i_req_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_req_read(d_req_read), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sampling on the active edge sees the pre-update values, so this never races the tasks.
    always @(posedge clk) begin
        if (rst_n && i_resp) i_resp_seen <= i_resp_seen + 1;
        if (rst_n && d_resp) d_resp_seen <= d_resp_seen + 1;
        if (rst_n && ((pmem_read && pmem_write) || (i_resp && d_resp))) overlap_seen <= overlap_seen + 1;
    end

    task automatic pulse_resp(input int delay, input lc3b_block data);
        repeat (delay) @(negedge clk);
        pmem_resp = 1'b1;
        pmem_rdata = data;
        @(negedge clk);
        pmem_resp = 1'b0;
        pmem_rdata = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({pmem_read, pmem_write, i_resp, d_resp, err_timeout} !== 5'b0) $display("[TB] FAIL reset_ctrl: got %b expected 00000", {pmem_read, pmem_write, i_resp, d_resp, err_timeout}); else n_pass++;
        n_checks++; if ({pmem_addr, pmem_wdata, i_rdata, d_rdata} !== '0) $display("[TB] FAIL reset_data: got addr %h wdata %h expected zeros", pmem_addr, pmem_wdata); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i_fill;
        int i0, d0;
        i0 = i_resp_seen; d0 = d_resp_seen;
        i_req_read = 1'b1; i_req_addr = 16'h1234;
        @(negedge clk);
        n_checks++; if ({pmem_read, pmem_write} !== 2'b10) $display("[TB] FAIL ifill_strobe: got %b expected 10", {pmem_read, pmem_write}); else n_pass++;
        n_checks++; if (pmem_addr !== 16'h1230) $display("[TB] FAIL ifill_addr: got %h expected 1230", pmem_addr); else n_pass++;
        pulse_resp(3, PAT_A);
        n_checks++; if ({i_resp, d_resp, pmem_read} !== 3'b100) $display("[TB] FAIL ifill_resp: got %b expected 100", {i_resp, d_resp, pmem_read}); else n_pass++;
        n_checks++; if (i_rdata !== PAT_A) $display("[TB] FAIL ifill_rdata: got %h expected %h", i_rdata, PAT_A); else n_pass++;
        i_req_read = 1'b0;
        @(negedge clk);
        n_checks++; if (i_resp !== 1'b0) $display("[TB] FAIL ifill_pulse_len: got %b expected 0", i_resp); else n_pass++;
        @(negedge clk);
        n_checks++; if ((i_resp_seen - i0) !== 1 || (d_resp_seen - d0) !== 0) $display("[TB] FAIL ifill_pulse_count: got i %0d d %0d expected i 1 d 0", i_resp_seen - i0, d_resp_seen - d0); else n_pass++;
    endtask

    task automatic test_priority;
        int ov0;
        ov0 = overlap_seen;
        d_req_write = 1'b1; d_req_addr = 16'h2345; d_wdata = PAT_W;
        i_req_read = 1'b1; i_req_addr = 16'h3008;
        @(negedge clk);
        n_checks++; if ({pmem_read, pmem_write} !== 2'b01) $display("[TB] FAIL prio_d_first: got %b expected 01", {pmem_read, pmem_write}); else n_pass++;
        n_checks++; if (pmem_wdata !== PAT_W || pmem_addr !== 16'h2340) $display("[TB] FAIL prio_wdata: got %h @%h expected %h @2340", pmem_wdata, pmem_addr, PAT_W); else n_pass++;
        pulse_resp(1, PAT_X);
        n_checks++; if ({d_resp, i_resp} !== 2'b10) $display("[TB] FAIL prio_d_resp: got %b expected 10", {d_resp, i_resp}); else n_pass++;
        d_req_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({pmem_read, pmem_write} !== 2'b10 || pmem_addr !== 16'h3000) $display("[TB] FAIL prio_i_second: got %b @%h expected 10 @3000", {pmem_read, pmem_write}, pmem_addr); else n_pass++;
        pulse_resp(0, PAT_Y);
        n_checks++; if (i_resp !== 1'b1 || i_rdata !== PAT_Y) $display("[TB] FAIL prio_i_resp: got %b %h expected 1 %h", i_resp, i_rdata, PAT_Y); else n_pass++;
        i_req_read = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (overlap_seen !== ov0) $display("[TB] FAIL prio_overlap: got %0d expected %0d", overlap_seen, ov0); else n_pass++;
    endtask

    task automatic test_timeout;
        int held;
        held = 0;
        d_req_read = 1'b1; d_req_addr = 16'h6000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pmem_read === 1'b1 && err_timeout === 1'b0) held++;
        end
        n_checks++; if (held !== 8) $display("[TB] FAIL tmo_held: got %0d cycles expected 8", held); else n_pass++;
        @(negedge clk);
        n_checks++; if ({pmem_read, d_resp, err_timeout} !== 3'b011) $display("[TB] FAIL tmo_done: got %b expected 011", {pmem_read, d_resp, err_timeout}); else n_pass++;
        n_checks++; if (d_rdata !== '0) $display("[TB] FAIL tmo_rdata: got %h expected 0", d_rdata); else n_pass++;
        d_req_read = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({err_timeout, d_resp} !== 2'b10) $display("[TB] FAIL tmo_sticky: got %b expected 10", {err_timeout, d_resp}); else n_pass++;
    endtask

    task automatic test_reset_mid_serve;
        int d0;
        d_req_read = 1'b1; d_req_addr = 16'h7000;
        @(negedge clk);
        n_checks++; if (pmem_read !== 1'b1) $display("[TB] FAIL rst_pre_strobe: got %b expected 1", pmem_read); else n_pass++;
        d0 = d_resp_seen;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({pmem_read, err_timeout, pmem_addr} !== 18'b0) $display("[TB] FAIL rst_async: got rd %b err %b addr %h expected 0", pmem_read, err_timeout, pmem_addr); else n_pass++;
        d_req_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (d_resp_seen !== d0) $display("[TB] FAIL rst_no_resp: got %0d expected %0d", d_resp_seen, d0); else n_pass++;
        d_req_read = 1'b1; d_req_addr = 16'h701F;
        @(negedge clk);
        n_checks++; if (pmem_read !== 1'b1 || pmem_addr !== 16'h7010) $display("[TB] FAIL rst_reissue: got %b @%h expected 1 @7010", pmem_read, pmem_addr); else n_pass++;
        pulse_resp(2, PAT_Z);
        n_checks++; if (d_resp !== 1'b1 || d_rdata !== PAT_Z) $display("[TB] FAIL rst_reissue_resp: got %b %h expected 1 %h", d_resp, d_rdata, PAT_Z); else n_pass++;
        d_req_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_latch;
        int stable;
        stable = 0;
        d_req_read = 1'b1; d_req_addr = 16'h4000;
        @(negedge clk);
        d_req_addr = 16'h5000;
        for (int k = 0; k < 4; k++) begin
            if (pmem_addr === 16'h4000 && pmem_read === 1'b1) stable++;
            if (k < 3) @(negedge clk);
        end
        n_checks++; if (stable !== 4) $display("[TB] FAIL latch_addr: got %0d stable cycles (now %h) expected 4", stable, pmem_addr); else n_pass++;
        pulse_resp(0, PAT_W);
        n_checks++; if (d_resp !== 1'b1 || d_rdata !== PAT_W) $display("[TB] FAIL latch_resp: got %b %h expected 1 %h", d_resp, d_rdata, PAT_W); else n_pass++;
        d_req_read = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEM_ARB_RR_EN
    task automatic test_round_robin;
        lc3b_word expect_addr [3];
        expect_addr[0] = 16'h2000; expect_addr[1] = 16'h1000; expect_addr[2] = 16'h2000;
        test_reset;
        i_req_read = 1'b1; i_req_addr = 16'h1000;
        d_req_read = 1'b1; d_req_addr = 16'h2000;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_checks++; if (pmem_addr !== expect_addr[t]) $display("[TB] FAIL rr_grant%0d: got %h expected %h", t, pmem_addr, expect_addr[t]); else n_pass++;
            pulse_resp(0, PAT_A);
            if (t == 2) begin
                i_req_read = 1'b0;
                d_req_read = 1'b0;
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        i_req_read = 1'b0; i_req_addr = '0;
        d_req_read = 1'b0; d_req_write = 1'b0; d_req_addr = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        @(negedge clk);
        test_reset;
        test_i_fill;
        test_priority;
        test_timeout;
        test_reset_mid_serve;
        test_addr_latch;
`ifdef MEM_ARB_RR_EN
        test_round_robin;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
